// File: rtl/pp_accum_pkg.sv
// Shared constants and FSM state type for the partial-product accumulator.
// The default geometry is a 108x108 multiply built from 27x18 limb products.
package pp_accum_pkg;
   localparam int RADIX  = 108;
   localparam int A_W    = 27;
   localparam int B_W    = 18;
   localparam int PP_W   = A_W + B_W;
   localparam int N_A    = 4;
   localparam int N_B    = 6;
   localparam int N_PP   = N_A * N_B;
   localparam int BANK_W = N_PP * PP_W;
   // A row needs headroom for the carries out of its N_B shifted terms.
   localparam int ROW_W  = PP_W + B_W * (N_B - 1) + $clog2(N_B);
   localparam int PROD_W = 2 * RADIX;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/pp_row_sum.sv
// Combinational sum of one row of partial products: sum_i pp[i] << (B_W*i).
// The result is wide enough that no carry is ever dropped inside a row.
module pp_row_sum #(
   parameter int PP_W = pp_accum_pkg::PP_W,
   parameter int B_W  = pp_accum_pkg::B_W,
   parameter int N_B  = pp_accum_pkg::N_B
) (
   input  logic [N_B-1:0][PP_W-1:0]                    pp,
   output logic [PP_W+B_W*(N_B-1)+$clog2(N_B)-1:0]     row
);
   localparam int ROW_W = PP_W + B_W * (N_B - 1) + $clog2(N_B);

   always_comb begin
      row = '0;
      for (int i = 0; i < N_B; i++)
         row = row + (ROW_W'(pp[i]) << (B_W * i));
   end
endmodule

// File: rtl/pp_accum.sv
// Reconstructs a wide product from a bank of limb partial products, one
// A-limb row per cycle, then holds the result until the consumer takes it.
module pp_accum #(
   parameter int RADIX = pp_accum_pkg::RADIX,
   parameter int A_W   = pp_accum_pkg::A_W,
   parameter int B_W   = pp_accum_pkg::B_W,
   parameter int PP_W  = pp_accum_pkg::PP_W,
   parameter int N_A   = pp_accum_pkg::N_A,
   parameter int N_B   = pp_accum_pkg::N_B
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_A*N_B*PP_W-1:0]     pp_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2*RADIX-1:0]          product,
   output logic                        busy
);
   import pp_accum_pkg::state_t;
   import pp_accum_pkg::IDLE;
   import pp_accum_pkg::ACCUM;
   import pp_accum_pkg::DONE;

   localparam int PROD_W = 2 * RADIX;
   localparam int ROW_W  = PP_W + B_W * (N_B - 1) + $clog2(N_B);
   localparam int CNT_W  = (N_A > 1) ? $clog2(N_A) : 1;

   state_t                          state, state_nxt;
   logic [N_A-1:0][N_B-1:0][PP_W-1:0] pp_q;
   logic [PROD_W-1:0]               acc;
   logic [CNT_W-1:0]                row_cnt;
   logic [ROW_W-1:0]                row;
   logic                            accept, last_row;

   assign accept   = in_valid && in_ready;
   assign last_row = (row_cnt == CNT_W'(N_A - 1));

   // Single row adder, time-shared across rows by the row counter.
   pp_row_sum #(.PP_W(PP_W), .B_W(B_W), .N_B(N_B)) u_row (
      .pp  (pp_q[row_cnt]),
      .row (row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = ACCUM;
         ACCUM:   if (last_row)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      in_ready  = rst_n && (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      product   = (state == DONE) ? acc : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp_q    <= '0;
         acc     <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         pp_q    <= pp_in;
         acc     <= '0;
         row_cnt <= '0;
      end else if (state == ACCUM) begin
         // Bits shifted past the product width are dropped (mod 2^PROD_W).
         acc     <= acc + (PROD_W'(row) << (A_W * int'(row_cnt)));
         row_cnt <= row_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pp_accum.sv
// Bench for pp_accum: table of banks with expected products, a scoreboard
// queue, plus hand-written sequences for input blocking and mid-run reset.
module tb_pp_accum;
   localparam int BW = 1080;
   localparam int PW = 216;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [BW-1:0] pp_in;
   logic [PW-1:0] product;

   int tests = 0;
   int fails = 0;
   logic [PW-1:0] sb[$];

   typedef struct {
      string         name;
      logic [BW-1:0] pp;
      logic [PW-1:0] exp;
      int            hold;
      bit            inject;
   } vec_t;
   vec_t tv[5];

   pp_accum dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pp_in(pp_in), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s act=%h req=%h", nm, act, req);
      end
   endtask

   function automatic logic [BW-1:0] make_bank(input logic [107:0] a, input logic [107:0] b);
      logic [BW-1:0] bk;
      logic [44:0]   p;
      bk = '0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 6; i++) begin
            p = 45'(a[27*j +: 27]) * 45'(b[18*i +: 18]);
            bk[(j*6+i)*45 +: 45] = p;
         end
      return bk;
   endfunction

   // Reference: each slice individually weighted by 2^(27j+18i), mod 2^216.
   function automatic logic [PW-1:0] ref_prod(input logic [BW-1:0] bk);
      logic [PW-1:0] s;
      s = '0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 6; i++)
            s = s + (PW'(bk[(j*6+i)*45 +: 45]) << (27*j + 18*i));
      return s;
   endfunction

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      chk({nm, "_ready"}, PW'(in_ready), PW'(1));
   endtask

   task automatic send(input vec_t v);
      int   edges;
      bit   rdy_bad, stable;
      logic [PW-1:0] exp;
      wait_ready(v.name);
      in_valid = 1'b1;
      pp_in    = v.pp;
      sb.push_back(v.exp);
      @(posedge clk);
      @(negedge clk);
      in_valid = v.inject;
      if (v.inject) pp_in = ~v.pp;
      rdy_bad = in_ready;
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk); edges++;
         @(negedge clk);
         if (v.inject && in_ready) rdy_bad = 1'b1;
         if (v.inject) pp_in = {$urandom, $urandom, $urandom};
      end
      in_valid = 1'b0;
      chk({v.name, "_latency"}, PW'(edges), PW'(4));
      if (v.inject) chk({v.name, "_ready_low"}, PW'(rdy_bad), PW'(0));
      if (sb.size() == 0) begin
         chk({v.name, "_sb_empty"}, PW'(0), PW'(1));
         exp = '0;
      end else exp = sb.pop_front();
      stable = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
         if (!out_valid || product !== exp) stable = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      if (v.hold > 0) chk({v.name, "_hold_stable"}, PW'(stable), PW'(1));
      chk({v.name, "_product"}, product, exp);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({v.name, "_ov_drop"}, PW'(out_valid), PW'(0));
      chk({v.name, "_prod_zero"}, product, '0);
      chk({v.name, "_idle_ready"}, PW'(in_ready), PW'(1));
   endtask

   initial begin
      logic [107:0] ra, rb;
      bit ov_seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pp_in = '0;

      ra = 108'({$urandom, $urandom, $urandom, $urandom});
      rb = 108'({$urandom, $urandom, $urandom, $urandom});
      tv[0] = '{"zero",   make_bank(108'd0, 108'd0), '0, 0, 1'b0};
      tv[1] = '{"allone", make_bank({108{1'b1}}, {108{1'b1}}),
                PW'(0) - (PW'(1) << 109) + PW'(1), 1, 1'b0};
      tv[2] = '{"a3b5",   make_bank(108'd3, 108'd5), PW'(15), 10, 1'b0};
      tv[3] = '{"satpp",  {BW{1'b1}}, ref_prod({BW{1'b1}}), 2, 1'b0};
      tv[4] = '{"rand",   make_bank(ra, rb), PW'(ra) * PW'(rb), 0, 1'b1};

      repeat (3) @(negedge clk);
      chk("rst_in_ready", PW'(in_ready), PW'(0));
      chk("rst_busy", PW'(busy), PW'(0));
      chk("rst_out_valid", PW'(out_valid), PW'(0));
      chk("rst_product", product, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", PW'(in_ready), PW'(1));

      // out_ready asserted while idle must be ignored
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      chk("idle_oready_ov", PW'(out_valid), PW'(0));

      for (int t = 0; t < 5; t++) send(tv[t]);

      // Reset in the middle of accumulation (row counter at 2)
      wait_ready("mid_rst");
      in_valid = 1'b1;
      pp_in    = tv[3].pp;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("mid_rst_busy_before", PW'(busy), PW'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", PW'(busy), PW'(0));
      chk("mid_rst_ov", PW'(out_valid), PW'(0));
      chk("mid_rst_prod", product, '0);
      chk("mid_rst_ready", PW'(in_ready), PW'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ov_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      chk("mid_rst_no_ov", PW'(ov_seen), PW'(0));
      tv[4].inject = 1'b0;
      tv[4].name   = "after_rst";
      send(tv[4]);
      chk("sb_drained", PW'(sb.size()), PW'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
